// File: rtl/alu_exec.sv
// ============================================================================
//  Module   : alu_exec
//  Purpose  : RV32I execute-stage ALU with valid/ready ports; shifts iterate
//             one bit per cycle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] rv1,
  input  logic [XLEN-1:0] rv2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam logic [3:0] C_OP_ADD  = 4'd0;
  localparam logic [3:0] C_OP_SUB  = 4'd1;
  localparam logic [3:0] C_OP_SLT  = 4'd2;
  localparam logic [3:0] C_OP_SLTU = 4'd3;
  localparam logic [3:0] C_OP_XOR  = 4'd4;
  localparam logic [3:0] C_OP_OR   = 4'd5;
  localparam logic [3:0] C_OP_AND  = 4'd6;
  localparam logic [3:0] C_OP_SLL  = 4'd7;
  localparam logic [3:0] C_OP_SRL  = 4'd8;
  localparam logic [3:0] C_OP_SRA  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            out_valid_q;
  logic [4:0]      cnt_q, cnt_d;
  logic [3:0]      shop_q, shop_d;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] shifted;

  // Single-cycle datapath; reserved codes fall through to zero.
  always_comb begin
    alu_res = '0;
    case (op)
      C_OP_ADD:  alu_res = rv1 + rv2;
      C_OP_SUB:  alu_res = rv1 - rv2;
      C_OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rv1) < $signed(rv2))};
      C_OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (rv1 < rv2)};
      C_OP_XOR:  alu_res = rv1 ^ rv2;
      C_OP_OR:   alu_res = rv1 | rv2;
      C_OP_AND:  alu_res = rv1 & rv2;
      default:   alu_res = '0;
    endcase
  end

  // One-bit step of the iterative shifter.
  always_comb begin
    shifted = {result_q[XLEN-2:0], 1'b0};
    if (shop_q == C_OP_SRL) begin
      shifted = {1'b0, result_q[XLEN-1:1]};
    end else if (shop_q == C_OP_SRA) begin
      shifted = {result_q[XLEN-1], result_q[XLEN-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    shop_d   = shop_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == C_OP_SLL || op == C_OP_SRL || op == C_OP_SRA) begin
            result_d = rv1;
            cnt_d    = rv2[4:0];
            shop_d   = op;
            if (rv2[4:0] == 5'd0) begin
              zero_d  = (rv1 == '0);
              state_d = S_DONE;
            end else begin
              state_d = S_SHIFT;
            end
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        result_d = shifted;
        cnt_d    = cnt_q - 5'd1;
        // zero tracks only the final shifted value
        if (cnt_q == 5'd1) begin
          zero_d  = (shifted == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= 5'd0;
      shop_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= (state_d == S_DONE);
      cnt_q       <= cnt_d;
      shop_q      <= shop_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
//  Module   : tb_alu_exec
//  Purpose  : Randomized self-checking bench for alu_exec against a
//             behavioural model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] rv1;
  logic [31:0] rv2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int   n_vec = 0;
  int   n_err = 0;
  logic prev_zero;

  always #5 clk = ~clk;

  alu_exec #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rv1       (rv1),
    .rv2       (rv2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (o)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a ^ b;
      4'd5:    return a | b;
      4'd6:    return a & b;
      4'd7:    return a << sh;
      4'd8:    return a >> sh;
      4'd9:    return 32'($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] o, input logic [31:0] b);
    if ((o == 4'd7 || o == 4'd8 || o == 4'd9) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Entered at a falling edge with the DUT idle; leaves at a falling edge idle.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int stall);
    logic [31:0] e;
    int          lat;
    e = model(o, a, b);
    check("idle_in_ready", in_ready, 1);
    op        = o;
    rv1       = a;
    rv2       = b;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    lat      = 1;
    in_valid = 1'b0;
    op       = 4'($urandom);
    rv1      = $urandom;
    rv2      = $urandom;
    while (!out_valid && lat < 40) begin
      check("busy_in_ready", in_ready, 0);
      check("shift_zero_hold", zero, prev_zero);
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    check("out_valid", out_valid, 1);
    check("latency", lat, model_lat(o, b));
    check("result", result, e);
    check("zero", zero, (e == 32'd0));
    for (int k = 1; k < stall; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_result", result, e);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    prev_zero = (e == 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'd0;
    rv1       = 32'd0;
    rv2       = 32'd0;
    prev_zero = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    reset = 1'b0;

    run_op(4'd0, 32'd5, 32'd7, 0);
    run_op(4'd1, 32'd3, 32'd3, 0);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd3, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd9, 32'h8000_0000, 32'h24, 0);
    run_op(4'd8, 32'h8000_0000, 32'h24, 0);
    run_op(4'd7, 32'd1, 32'd31, 0);
    run_op(4'd7, 32'h1234, 32'h20, 0);
    run_op(4'd4, 32'hF0F0, 32'h0FF0, 4);
    run_op(4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 0);

    // Reset three cycles into a long shift.
    check("pre_mid_in_ready", in_ready, 1);
    op       = 4'd8;
    rv1      = 32'hABCD_0123;
    rv2      = 32'd20;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_zero", zero, 1);
    check("midrst_in_ready", in_ready, 1);
    prev_zero = 1'b1;
    run_op(4'd6, 32'hFF, 32'h0F, 0);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  o;
      o = 4'($urandom_range(0, 15));
      a = (i % 8 == 0) ? 32'd0 : $urandom;
      b = (i % 5 == 0) ? a : $urandom;
      run_op(o, a, b, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
